// File: rtl/mgmt_spi_pkg.sv
// Shared constants for the management SPI master: frame commands, slave
// register map and control-register bit positions.
package mgmt_spi_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam int         FRAME_BITS = 24;

    localparam logic [7:0] ADDR0_START_H = 8'h00;
    localparam logic [7:0] ADDR0_START_L = 8'h01;
    localparam logic [7:0] ADDR0_END_H   = 8'h02;
    localparam logic [7:0] ADDR0_END_L   = 8'h03;
    localparam logic [7:0] ADDR1_START_H = 8'h04;
    localparam logic [7:0] ADDR1_START_L = 8'h05;
    localparam logic [7:0] ADDR1_END_H   = 8'h06;
    localparam logic [7:0] ADDR1_END_L   = 8'h07;
    localparam logic [7:0] ADDR2_START_H = 8'h08;
    localparam logic [7:0] ADDR2_START_L = 8'h09;
    localparam logic [7:0] ADDR2_END_H   = 8'h0A;
    localparam logic [7:0] ADDR2_END_L   = 8'h0B;
    localparam logic [7:0] CTRL_REG      = 8'h0C;
    localparam logic [7:0] STATUS_REG    = 8'h0D;

    localparam int CTRL_MODE_LO    = 0;
    localparam int CTRL_MODE_HI    = 1;
    localparam int CTRL_RANGE0_EN  = 2;
    localparam int CTRL_RANGE1_EN  = 3;
    localparam int CTRL_FLASH0_SEL = 4;
    localparam int CTRL_FLASH1_SEL = 5;
    localparam int CTRL_HOST_SEL   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } mgmt_state_e;

    // Reads always carry a zero data byte so the slave sees a clean frame.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic       write,
        input logic [7:0] addr,
        input logic [7:0] wdata
    );
        return {(write ? CMD_WRITE : CMD_READ), addr, (write ? wdata : 8'h00)};
    endfunction

endpackage

// File: rtl/mgmt_spi_clkgen.sv
// SCK generator: toggles sck every CLK_DIV enabled cycles and flags the
// cycle in which a rising or falling transition is about to be registered.
module mgmt_spi_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise_evt,
    output logic fall_evt
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_q, div_d;
    logic          sck_q, sck_d;
    logic          tc;

    always_comb begin
        tc    = en && (div_q == DIV_LAST);
        div_d = div_q;
        sck_d = sck_q;
        // Disabled means parked: sck low and the divider restarted, so the
        // first half-period of every frame is a full CLK_DIV cycles.
        if (!en) begin
            div_d = '0;
            sck_d = 1'b0;
        end else if (tc) begin
            div_d = '0;
            sck_d = ~sck_q;
        end else begin
            div_d = div_q + CW'(1);
        end
        rise_evt = tc && !sck_q;
        fall_evt = tc && sck_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/mgmt_spi_master.sv
// Management SPI master: one {cmd, addr, data} mode-0 frame per request.
// Define MGMT_SPI_READBACK_EN to follow every write with a verifying read.
module mgmt_spi_master
    import mgmt_spi_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       mgmt_clk,
    output logic       mgmt_cs_n,
    output logic       mgmt_mosi,
    input  logic       mgmt_miso
);

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);
    localparam logic [4:0]  LAST_BIT   = 5'(FRAME_BITS - 1);

    mgmt_state_e           state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [4:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [7:0]            rx_q, rx_d;
    logic                  req_ready_q, req_ready_d;
    logic                  cs_n_q, cs_n_d;
    logic                  mosi_q, mosi_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [7:0]            rsp_rdata_q, rsp_rdata_d;
`ifdef MGMT_SPI_READBACK_EN
    logic                  rsp_err_q, rsp_err_d;
    logic                  rb_pend_q, rb_pend_d;
    logic                  rb_rd_q, rb_rd_d;
    logic                  rb_chk_q, rb_chk_d;
    logic [7:0]            rb_addr_q, rb_addr_d;
    logic [7:0]            rb_wdata_q, rb_wdata_d;
`endif

    logic shift_en;
    logic sck;
    logic rise_evt;
    logic fall_evt;

    assign shift_en = (state_q == ST_SHIFT);

    mgmt_spi_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk     (clk),
        .rst     (rst),
        .en      (shift_en),
        .sck     (sck),
        .rise_evt(rise_evt),
        .fall_evt(fall_evt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        req_ready_d = req_ready_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef MGMT_SPI_READBACK_EN
        rsp_err_d   = rsp_err_q;
        rb_pend_d   = rb_pend_q;
        rb_rd_d     = rb_rd_q;
        rb_chk_d    = rb_chk_q;
        rb_addr_d   = rb_addr_q;
        rb_wdata_d  = rb_wdata_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    tx_d        = build_frame(req_write, req_addr, req_wdata);
                    mosi_d      = tx_d[FRAME_BITS-1];
                    cs_n_d      = 1'b0;
                    req_ready_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_SETUP;
`ifdef MGMT_SPI_READBACK_EN
                    rb_pend_d   = req_write;
                    rb_chk_d    = 1'b0;
                    rb_addr_d   = req_addr;
                    rb_wdata_d  = req_wdata;
`endif
                end
            end

            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_SHIFT: begin
                if (rise_evt) begin
                    rx_d = {rx_q[6:0], mgmt_miso};
                end
                // The frame ends on the 24th falling edge so sck is already
                // low when cs_n starts its hold time.
                if (fall_evt) begin
                    tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
                    mosi_d = tx_q[FRAME_BITS-2];
                    if (bit_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end

            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cs_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
`ifdef MGMT_SPI_READBACK_EN
                    if (rb_pend_q) begin
                        rb_pend_d = 1'b0;
                        rb_rd_d   = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rx_q;
                        rsp_err_d   = rb_chk_q && (rx_q != rb_wdata_q);
                        rb_chk_d    = 1'b0;
                    end
`else
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rx_q;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
`ifdef MGMT_SPI_READBACK_EN
                    if (rb_rd_q) begin
                        tx_d     = build_frame(1'b0, rb_addr_q, 8'h00);
                        mosi_d   = tx_d[FRAME_BITS-1];
                        cs_n_d   = 1'b0;
                        rb_rd_d  = 1'b0;
                        rb_chk_d = 1'b1;
                        state_d  = ST_SETUP;
                    end else begin
                        req_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
`else
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                cs_n_d      = 1'b1;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            req_ready_q <= 1'b1;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
`ifdef MGMT_SPI_READBACK_EN
            rsp_err_q   <= 1'b0;
            rb_pend_q   <= 1'b0;
            rb_rd_q     <= 1'b0;
            rb_chk_q    <= 1'b0;
            rb_addr_q   <= 8'h00;
            rb_wdata_q  <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            req_ready_q <= req_ready_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef MGMT_SPI_READBACK_EN
            rsp_err_q   <= rsp_err_d;
            rb_pend_q   <= rb_pend_d;
            rb_rd_q     <= rb_rd_d;
            rb_chk_q    <= rb_chk_d;
            rb_addr_q   <= rb_addr_d;
            rb_wdata_q  <= rb_wdata_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mgmt_clk  = sck;
    assign mgmt_cs_n = cs_n_q;
    assign mgmt_mosi = mosi_q;
`ifdef MGMT_SPI_READBACK_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: doc/mgmt_spi_master.md
Name: mgmt_spi_master

Overview:
SPI master (initiator) for the management configuration interface, in the system `clk` domain. It turns single-register write and read requests into 3-byte management frames: {cmd, addr, data}. Commands are 0x02 for write and 0x03 for read. Frames use SPI mode 0 (SCK idles low, data sampled on the rising edge) and are sent MSB first. Used by on-chip bring-up logic and the test harness to program address ranges and control bits in the management slave.

Parameters:
CLK_DIV, 2, SCK half-period in clk cycles (>=1)
CS_SETUP, 2, clk cycles with cs_n low before the first SCK rising edge (>=1)
CS_HOLD, 2, clk cycles after the last SCK falling edge before cs_n rises (>=1)
CS_GAP, 2, minimum clk cycles cs_n stays high between frames (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  master idle; request accepted when req_valid & req_ready
req_write  in  1  1 = write (cmd 0x02), 0 = read (cmd 0x03)
req_addr  in  8  register address
req_wdata  in  8  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse when the frame completes
rsp_rdata  out  8  read data; valid with rsp_valid, holds until the next rsp_valid
rsp_err  out  1  readback mismatch (feature only); valid with rsp_valid
mgmt_clk  out  1  SCK
mgmt_cs_n  out  1  chip select, active low
mgmt_mosi  out  1  serial data out
mgmt_miso  in  1  serial data in

Behaviour:
- Reset values (asynchronous): mgmt_cs_n=1, mgmt_clk=0, mgmt_mosi=0, rsp_valid=0, rsp_rdata=0x00, rsp_err=0, req_ready=1, state IDLE.
- Reset mid-frame: the frame is aborted immediately with the same values as above; no rsp_valid is produced.
- IDLE:
  - req_ready=1.
  - On accept, latch tx = {cmd, req_addr, wdata}. wdata is req_wdata for writes and 0x00 for reads.
  - Go to SETUP.
- SETUP:
  - req_ready=0, cs_n=0, sck=0, mosi=tx[23].
  - Lasts CS_SETUP cycles, then SHIFT.
- SHIFT:
  - A divider counts CLK_DIV cycles per half-period; each terminal count toggles sck.
  - SCK 0->1: shift mgmt_miso into rx[7:0] (LSB in).
  - SCK 1->0: shift tx left, mosi=tx[22] (next bit).
  - 24 rising edges (48 half-periods), ending with sck=0; then HOLD.
- HOLD:
  - cs_n=0, sck=0, CS_HOLD cycles.
  - Then cs_n=1, rsp_valid=1 for one cycle, rsp_rdata=rx (the bits sampled on rising edges 17..24), go to GAP.
- GAP: cs_n=1, req_ready=0 for CS_GAP cycles, then IDLE.
- Latency:
  - Accept to rsp_valid = CS_SETUP + 48*CLK_DIV + CS_HOLD cycles.
  - Accept to next possible accept = that value + CS_GAP + 1.
- For writes, rsp_rdata is the data sampled during the data byte; the slave drives 0, so it is 0x00.
- req_valid while busy: ignored and not accepted; request inputs are sampled only at accept.
- The frame never truncates; cs_n never rises while sck=1.
- SCK changes only on divider terminal counts; no glitches. All outputs are registered.

Optional Feature:
MGMT_SPI_READBACK_EN
- Defined:
  - Each accepted write is followed, after CS_GAP cycles, automatically by a read frame to the same address.
  - rsp_valid fires only after the read frame.
  - rsp_rdata = value read back; rsp_err = (readback != req_wdata).
  - Reads behave as in the base design, with rsp_err=0.
- Undefined: rsp_err is tied to 0 and writes are single frames.

Decomposition:
- Package mgmt_spi_pkg:
  - CMD_WRITE=8'h02, CMD_READ=8'h03, FRAME_BITS=24.
  - Register address constants 0x00..0x0D (ADDR0_START_H .. STATUS_REG).
  - Control bit index constants (mode[1:0], range enables [2]/[3], flash selects [4]/[5], host select [6]).
- Sub-module mgmt_spi_clkgen: CLK_DIV divider producing sck plus one-cycle rise_evt and fall_evt strobes, enabled only in SHIFT.

Test Plan:
- Write, defaults: accept addr 0x0C, wdata 0x25 -> MOSI sampled on SCK rises is 0x02,0x0C,0x25. Exactly 24 rises. rsp_valid at cycle 100 after accept. Slave model control reg = 0x25.
- Read: slave model holds 0xA5 at 0x0D; read addr 0x0D -> MOSI 0x03,0x0D,0x00; rsp_rdata=0xA5; rsp_err=0.
- Back-to-back: req_valid held with two writes (0x00=0x12, 0x01=0x34) -> second accept exactly CS_GAP+1 cycles after the first rsp_valid. cs_n is high for >=2 cycles between frames. Both registers are updated.
- Busy/reset: change req_addr during a frame -> frame is unchanged. Assert rst at SCK rise 10 -> cs_n=1, sck=0, no rsp_valid. The next write 0x02=0x56 completes correctly.
- CLK_DIV=1, CS_SETUP=CS_HOLD=CS_GAP=1: write/read 0x05=0xC3 -> readback 0xC3; latency 50 cycles.
- MGMT_SPI_READBACK_EN: write 0x03=0x7E with a faithful model -> two frames, rsp_rdata=0x7E, rsp_err=0. With the model corrupting bit0 -> rsp_rdata=0x7F, rsp_err=1.
